// File: rtl/id_ex_skid_pkg.sv
// Shared decode constants and bundle sizing for the ID/EX pipeline slice.
package id_ex_skid_pkg;

  localparam logic [4:0] NO_OP = 5'd0;
  localparam logic [4:0] ADD   = 5'd1;
  localparam logic [4:0] SUB   = 5'd2;
  localparam logic [4:0] AND_OP = 5'd3;
  localparam logic [4:0] OR_OP  = 5'd4;
  localparam logic [4:0] XOR_OP = 5'd5;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD    = 3'b000;

  // pc, op_a, op_b, rs2_data + three 5-bit indices + opcode + func3 + ALU code + three enables
  function automatic int id_ex_w(input int xlen, input int aluctrl_w);
    return 4 * xlen + 3 * 5 + 7 + 3 + aluctrl_w + 3;
  endfunction

  localparam int ID_EX_W = id_ex_w(32, 5);

endpackage

// File: rtl/id_ex_skid_skid_buf.sv
// Generic 2-entry valid/ready slice: main register M feeds the output, skid register S
// absorbs one bundle so in_ready_o comes straight from a flop.
module skid_buf #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         m_valid_q, m_valid_d;
  logic         s_valid_q, s_valid_d;
  logic [W-1:0] m_data_q, m_data_d;
  logic [W-1:0] s_data_q, s_data_d;
  logic         accept_s, drain_s;

  assign accept_s    = in_valid_i & ~s_valid_q;
  assign drain_s     = m_valid_q & out_ready_i;
  assign in_ready_o  = ~s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;

  // Next-state selection; flush dominates and drops any same-cycle accept.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (drain_s) begin
        m_data_d  = s_data_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = m_valid_q;
      end
    end else if (!m_valid_q || drain_s) begin
      if (accept_s) begin
        m_data_d  = in_data_i;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      s_data_d  = in_data_i;
      s_valid_d = 1'b1;
    end else begin
      s_valid_d = s_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= RST_VAL;
      s_data_q  <= RST_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX elastic pipeline register: packs the decoded bundle through a 2-entry skid
// buffer and forces bubbles to be harmless (no register write, NO_OP ALU code).
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [XLEN-1:0]      id_op_a_i,
  input  logic [XLEN-1:0]      id_op_b_i,
  input  logic [XLEN-1:0]      id_rs2_data_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic [4:0]           id_rd_i,
  input  logic [6:0]           id_opcode_i,
  input  logic [2:0]           id_func3_i,
  input  logic [ALUCTRL_W-1:0] id_ALUctrl_i,
  input  logic                 id_reg_we_i,
  input  logic                 id_reg1_RE_i,
  input  logic                 id_reg2_RE_i,
  input  logic                 flush_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [XLEN-1:0]      ex_op_a_o,
  output logic [XLEN-1:0]      ex_op_b_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [4:0]           ex_rs1_o,
  output logic [4:0]           ex_rs2_o,
  output logic [4:0]           ex_rd_o,
  output logic [6:0]           ex_opcode_o,
  output logic [2:0]           ex_func3_o,
  output logic [ALUCTRL_W-1:0] ex_ALUctrl_o,
  output logic                 ex_reg_we_o,
  output logic                 ex_reg1_RE_o,
  output logic                 ex_reg2_RE_o
);

  localparam int W = id_ex_w(XLEN, ALUCTRL_W);
  localparam logic [W-1:0] RST_BUNDLE = {{(4 * XLEN + 25){1'b0}}, ALUCTRL_W'(NO_OP), 3'b000};

  logic [W-1:0]         in_bundle_s;
  logic [W-1:0]         out_bundle_s;
  logic                 ex_valid_s;
  logic [ALUCTRL_W-1:0] alu_raw_s;
  logic                 reg_we_raw_s;

  assign in_bundle_s = {id_pc_i, id_op_a_i, id_op_b_i, id_rs2_data_i,
                        id_rs1_i, id_rs2_i, id_rd_i, id_opcode_i, id_func3_i,
                        id_ALUctrl_i, id_reg_we_i, id_reg1_RE_i, id_reg2_RE_i};

  skid_buf #(
    .W       (W),
    .RST_VAL (RST_BUNDLE)
  ) u_skid_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (id_valid_i),
    .in_ready_o  (id_ready_o),
    .in_data_i   (in_bundle_s),
    .out_valid_o (ex_valid_s),
    .out_ready_i (ex_ready_i),
    .out_data_o  (out_bundle_s)
  );

  assign {ex_pc_o, ex_op_a_o, ex_op_b_o, ex_rs2_data_o,
          ex_rs1_o, ex_rs2_o, ex_rd_o, ex_opcode_o, ex_func3_o,
          alu_raw_s, reg_we_raw_s, ex_reg1_RE_o, ex_reg2_RE_o} = out_bundle_s;
  assign ex_valid_o = ex_valid_s;

  // Bubble gating: an empty slot must never write a register or issue an ALU op.
  always_comb begin
    ex_ALUctrl_o = ALUCTRL_W'(NO_OP);
    ex_reg_we_o  = 1'b0;
    if (ex_valid_s) begin
      ex_ALUctrl_o = alu_raw_s;
      ex_reg_we_o  = reg_we_raw_s;
    end else begin
      ex_ALUctrl_o = ALUCTRL_W'(NO_OP);
      ex_reg_we_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_skid.sv
// Randomized and directed bench for id_ex_skid against a queue-level model.
module tb_id_ex_skid;
  import id_ex_skid_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int BW   = 4 * XLEN + 25 + AW + 3;
  typedef logic [BW-1:0] bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid_i = 1'b0, id_ready_o, flush_i = 1'b0, ex_valid_o, ex_ready_i = 1'b0;
  logic [XLEN-1:0] id_pc_i = '0, id_op_a_i = '0, id_op_b_i = '0, id_rs2_data_i = '0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic [6:0] id_opcode_i = '0;
  logic [2:0] id_func3_i = '0;
  logic [AW-1:0] id_ALUctrl_i = '0;
  logic id_reg_we_i = 1'b0, id_reg1_RE_i = 1'b0, id_reg2_RE_i = 1'b0;
  logic [XLEN-1:0] ex_pc_o, ex_op_a_o, ex_op_b_o, ex_rs2_data_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [6:0] ex_opcode_o;
  logic [2:0] ex_func3_o;
  logic [AW-1:0] ex_ALUctrl_o;
  logic ex_reg_we_o, ex_reg1_RE_o, ex_reg2_RE_o;

  always #5 clk = ~clk;

  id_ex_skid #(.XLEN(XLEN), .ALUCTRL_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_op_a_i(id_op_a_i), .id_op_b_i(id_op_b_i),
    .id_rs2_data_i(id_rs2_data_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rd_i(id_rd_i), .id_opcode_i(id_opcode_i), .id_func3_i(id_func3_i),
    .id_ALUctrl_i(id_ALUctrl_i), .id_reg_we_i(id_reg_we_i),
    .id_reg1_RE_i(id_reg1_RE_i), .id_reg2_RE_i(id_reg2_RE_i),
    .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .ex_opcode_o(ex_opcode_o), .ex_func3_o(ex_func3_o),
    .ex_ALUctrl_o(ex_ALUctrl_o), .ex_reg_we_o(ex_reg_we_o),
    .ex_reg1_RE_o(ex_reg1_RE_o), .ex_reg2_RE_o(ex_reg2_RE_o)
  );

  bundle_t in_b, out_b;
  assign in_b  = {id_pc_i, id_op_a_i, id_op_b_i, id_rs2_data_i, id_rs1_i, id_rs2_i, id_rd_i,
                  id_opcode_i, id_func3_i, id_ALUctrl_i, id_reg_we_i, id_reg1_RE_i, id_reg2_RE_i};
  assign out_b = {ex_pc_o, ex_op_a_o, ex_op_b_o, ex_rs2_data_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
                  ex_opcode_o, ex_func3_o, ex_ALUctrl_o, ex_reg_we_o, ex_reg1_RE_o, ex_reg2_RE_o};

  // Reference: the slice is a FIFO of at most two bundles; the head is what EX sees.
  bundle_t mq[$];
  bundle_t last_head = '0;
  bit      hold_known = 1'b0;
  bit      chk_en = 1'b0;
  bit      m_drain, m_accept;
  int      errors = 0;
  int      checks = 0;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model update on each active edge, using the inputs the DUT sees at that edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      last_head  = '0;
      hold_known = 1'b1;
    end else if (flush_i) begin
      mq.delete();
      hold_known = 1'b0;
    end else begin
      m_drain  = (mq.size() > 0) && ex_ready_i;
      m_accept = id_valid_i && (mq.size() < 2);
      if (m_drain) void'(mq.pop_front());
      if (m_accept) mq.push_back(in_b);
      if (mq.size() > 0) begin
        last_head  = mq[0];
        hold_known = 1'b1;
      end
    end
  end

  // Compare outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("id_ready", 192'(id_ready_o), 192'(mq.size() < 2));
      check_eq("ex_valid", 192'(ex_valid_o), 192'(mq.size() > 0));
      if (mq.size() > 0) begin
        check_eq("bundle", 192'(out_b), 192'(mq[0]));
      end else begin
        check_eq("bubble_we", 192'(ex_reg_we_o), 192'(1'b0));
        check_eq("bubble_alu", 192'(ex_ALUctrl_o), 192'(NO_OP));
        if (hold_known) check_eq("hold_pc", 192'(ex_pc_o), 192'(last_head[BW-1 -: XLEN]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] pc,
                       input logic [4:0] alu, input bit we);
    id_valid_i    = v;
    ex_ready_i    = r;
    flush_i       = f;
    id_pc_i       = pc;
    id_ALUctrl_i  = alu;
    id_reg_we_i   = we;
    id_op_a_i     = $urandom;
    id_op_b_i     = $urandom;
    id_rs2_data_i = $urandom;
    id_rs1_i      = 5'($urandom);
    id_rs2_i      = 5'($urandom);
    id_rd_i       = 5'($urandom);
    id_opcode_i   = 7'($urandom);
    id_func3_i    = 3'($urandom);
    id_reg1_RE_i  = 1'($urandom);
    id_reg2_RE_i  = 1'($urandom);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, NO_OP, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Streaming
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(4 * i), ADD, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, NO_OP, 1'b0);
    tick();
    tick();

    // Backpressure: 0x18 waits in ID until the slice has room again
    drive(1'b1, 1'b0, 1'b0, 32'h10, ADD, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h14, ADD, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h18, ADD, 1'b1); tick();
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h18, ADD, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h18, ADD, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, NO_OP, 1'b0); tick();
    tick();

    // Flush with both slots full and a new bundle offered
    drive(1'b1, 1'b0, 1'b0, 32'h20, ADD, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h24, ADD, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 32'h28, ADD, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, NO_OP, 1'b0); tick();
    tick();

    // Bubble gating after a lone SUB drains
    drive(1'b1, 1'b1, 1'b0, 32'h30, SUB, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, NO_OP, 1'b0); tick();
    tick();
    check_eq("bubble_pc_kept", 192'(ex_pc_o), 192'(32'h30));

    // Reset mid-stream with both slots full; rst_n low between edges has no effect yet
    drive(1'b1, 1'b0, 1'b0, 32'h40, ADD, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h44, ADD, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, NO_OP, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("post_reset_valid", 192'(ex_valid_o), 192'(1'b0));
    check_eq("post_reset_ready", 192'(id_ready_o), 192'(1'b1));
    tick();

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
            $urandom, 5'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, NO_OP, 1'b0);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
